// File: rtl/uio_bus_arbiter.sv
`timescale 1ns/1ps
// uio_bus_arbiter: round-robin owner of a shared 8-bit uio bus.
// Grants whole bursts of len+1 beats with one bus-release cycle between owners.
module uio_bus_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned LENW = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*LENW-1:0]   req_len,
  input  logic [NREQ*8-1:0]      req_wdata,
  output logic [NREQ-1:0]        gnt,
  output logic                   beat,
  output logic                   done,
  output logic                   busy,
  output logic [7:0]             rdata,
  output logic                   rvalid,
  input  logic [7:0]             uio_in,
  output logic [7:0]             uio_out,
  output logic [7:0]             uio_oe
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } state_e;

  state_e          state_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   last_q;
  logic            wr_q;
  logic [LENW-1:0] cnt_q;
  logic [NREQ-1:0] gnt_q;
  logic            beat_q;
  logic            done_q;
  logic            busy_q;
  logic [7:0]      oe_q;
  logic [7:0]      rdata_q;
  logic            rvalid_q;

  logic [IW-1:0]   win_c;
  logic [IW-1:0]   cand_c;
  logic            found_c;
  logic [LENW-1:0] sel_len_c;
  logic            sel_wr_c;
  logic [7:0]      wdata_c;
  logic            rd_beat_c;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    win_c   = '0;
    cand_c  = '0;
    found_c = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand_c = IW'((32'(last_q) + k) % NREQ);
      if (!found_c && req[cand_c]) begin
        found_c = 1'b1;
        win_c   = cand_c;
      end
    end
  end

  // Per-requester field selection for the winner and the current owner.
  always_comb begin
    sel_len_c = '0;
    sel_wr_c  = 1'b0;
    wdata_c   = 8'h00;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (win_c == IW'(i)) begin
        sel_len_c = req_len[i*LENW +: LENW];
        sel_wr_c  = req_wr[i];
      end
      if (owner_q == IW'(i)) begin
        wdata_c = req_wdata[i*8 +: 8];
      end
    end
  end

  assign rd_beat_c = (state_q == XFER) && !wr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      last_q   <= IW'(NREQ - 1);
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      gnt_q    <= '0;
      beat_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      oe_q     <= 8'h00;
      rdata_q  <= 8'h00;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= rd_beat_c;
      if (rd_beat_c) begin
        rdata_q <= uio_in;
      end
      unique case (state_q)
        IDLE: begin
          if (found_c) begin
            state_q <= XFER;
            owner_q <= win_c;
            last_q  <= win_c;
            wr_q    <= sel_wr_c;
            cnt_q   <= sel_len_c;
            gnt_q   <= NREQ'(1) << win_c;
            beat_q  <= 1'b1;
            busy_q  <= 1'b1;
            done_q  <= (sel_len_c == '0);
            oe_q    <= sel_wr_c ? 8'hFF : 8'h00;
          end
        end
        XFER: begin
          // Counter holds beats still to go after the current one.
          if (cnt_q == '0) begin
            state_q <= TURN;
            gnt_q   <= '0;
            beat_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_q    <= 8'h00;
          end else begin
            cnt_q  <= cnt_q - 1'b1;
            done_q <= (cnt_q == LENW'(1));
          end
        end
        TURN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign beat    = beat_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign uio_oe  = oe_q;
  assign rdata   = rdata_q;
  assign rvalid  = rvalid_q;
  // Write data passes straight through from the owner during its own beats.
  assign uio_out = ((state_q == XFER) && wr_q) ? wdata_c : 8'h00;

endmodule

// File: tb/tb_uio_bus_arbiter.sv
`timescale 1ns/1ps
// tb_uio_bus_arbiter: directed scenarios plus random traffic, every cycle
// compared against a beats-remaining model of the bus.
module tb_uio_bus_arbiter;

  localparam int NREQ = 3;
  localparam int LENW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wr;
  logic [NREQ*LENW-1:0] req_len;
  logic [NREQ*8-1:0]    req_wdata;
  logic [NREQ-1:0]      gnt;
  logic                 beat;
  logic                 done;
  logic                 busy;
  logic [7:0]           rdata;
  logic                 rvalid;
  logic [7:0]           uio_in;
  logic [7:0]           uio_out;
  logic [7:0]           uio_oe;

  always #5 clk = ~clk;

  uio_bus_arbiter #(.NREQ(NREQ), .LENW(LENW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_wr    (req_wr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .beat      (beat),
    .done      (done),
    .busy      (busy),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .uio_in    (uio_in),
    .uio_out   (uio_out),
    .uio_oe    (uio_oe)
  );

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Model: beats left in the current burst (0 = none), plus a pending release cycle.
  int         m_rem;
  int         m_owner;
  int         m_last;
  bit         m_turn;
  bit         m_wr;
  bit         m_rvalid;
  logic [7:0] m_rdata;

  int              beats_seen;
  int              dones_seen;
  int              oe_beats;
  logic [NREQ-1:0] prev_gnt;
  int              grant_q[$];
  int              grant_t[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    logic [NREQ-1:0] e_gnt;
    logic [7:0]      e_oe;
    logic [7:0]      e_out;
    bit              found;
    int              c;
    @(negedge clk);
    e_gnt = (m_rem > 0) ? NREQ'(1 << m_owner) : '0;
    e_oe  = (m_rem > 0 && m_wr) ? 8'hFF : 8'h00;
    e_out = (e_oe == 8'hFF) ? req_wdata[m_owner*8 +: 8] : 8'h00;
    chk("gnt",     32'(gnt),     32'(e_gnt));
    chk("beat",    32'(beat),    32'(m_rem > 0));
    chk("done",    32'(done),    32'(m_rem == 1));
    chk("busy",    32'(busy),    32'(m_rem > 0 || m_turn));
    chk("uio_oe",  32'(uio_oe),  32'(e_oe));
    chk("uio_out", 32'(uio_out), 32'(e_out));
    chk("rvalid",  32'(rvalid),  32'(m_rvalid));
    chk("rdata",   32'(rdata),   32'(m_rdata));
    if (beat) beats_seen++;
    if (done) dones_seen++;
    if (beat && uio_oe == 8'hFF) oe_beats++;
    if (gnt != '0 && prev_gnt == '0) begin
      grant_q.push_back(int'(gnt));
      grant_t.push_back(cyc_n);
    end
    prev_gnt = gnt;
    // Advance the model across the coming rising edge.
    if (rst) begin
      m_rem = 0; m_turn = 0; m_last = NREQ - 1; m_rvalid = 0; m_rdata = 8'h00;
    end else begin
      m_rvalid = (m_rem > 0 && !m_wr);
      if (m_rvalid) m_rdata = uio_in;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) m_turn = 1;
      end else if (m_turn) begin
        m_turn = 0;
      end else begin
        found = 0;
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (!found && req[c]) begin
            found   = 1;
            m_owner = c;
            m_last  = c;
            m_wr    = req_wr[c];
            m_rem   = int'(req_len[c*LENW +: LENW]) + 1;
          end
        end
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic idle(input int n);
    req = '0;
    run(n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int exp_rr[4];
    exp_rr[0] = 1; exp_rr[1] = 2; exp_rr[2] = 4; exp_rr[3] = 1;
    rst = 1'b1; req = '0; req_wr = '0; req_len = '0; req_wdata = '0; uio_in = 8'h00;
    m_rem = 0; m_owner = 0; m_last = NREQ - 1; m_turn = 0; m_wr = 0;
    m_rvalid = 0; m_rdata = 8'h00; prev_gnt = '0;
    beats_seen = 0; dones_seen = 0; oe_beats = 0;
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_oe",   32'(uio_oe), 32'(8'h00));

    // Single 3-beat write from requester 0.
    req = 3'b001; req_wr = 3'b001; req_len = {4'd0, 4'd0, 4'd2}; req_wdata = {8'h00, 8'h00, 8'hA5};
    cyc();
    req = '0;
    chk("wr_gnt", 32'(gnt),     32'(3'b001));
    chk("wr_oe",  32'(uio_oe),  32'(8'hFF));
    chk("wr_out", 32'(uio_out), 32'(8'hA5));
    run(3);
    chk("wr_turn_busy", 32'(busy),   32'(1));
    chk("wr_turn_oe",   32'(uio_oe), 32'(8'h00));
    chk("wr_turn_gnt",  32'(gnt),    32'(0));
    cyc();
    chk("wr_idle_busy", 32'(busy), 32'(0));

    // Round-robin with all three requesting single-beat writes.
    do_reset();
    grant_q.delete(); grant_t.delete();
    req = 3'b111; req_wr = 3'b111; req_len = '0; req_wdata = {8'h33, 8'h22, 8'h11};
    run(12);
    idle(4);
    chk("rr_count", 32'(grant_q.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++)
      chk($sformatf("rr_gnt%0d", i), 32'((i < grant_q.size()) ? grant_q[i] : -1), 32'(exp_rr[i]));
    for (int i = 0; i < 3; i++)
      chk($sformatf("rr_gap%0d", i),
          32'((i + 1 < grant_t.size()) ? grant_t[i+1] - grant_t[i] : -1), 32'(3));

    // Two-beat read by requester 1.
    req = 3'b010; req_wr = 3'b000; req_len = {4'd0, 4'd1, 4'd0};
    cyc();
    req = '0; uio_in = 8'h3C;
    chk("rd_gnt", 32'(gnt),    32'(3'b010));
    chk("rd_oe",  32'(uio_oe), 32'(8'h00));
    cyc();
    chk("rd_data0",  32'(rdata),  32'(8'h3C));
    chk("rd_valid0", 32'(rvalid), 32'(1));
    uio_in = 8'hC3;
    cyc();
    chk("rd_data1",  32'(rdata),  32'(8'hC3));
    chk("rd_valid1", 32'(rvalid), 32'(1));
    cyc();
    chk("rd_valid_end", 32'(rvalid), 32'(0));
    idle(3);

    // Reset during beat 2 of a 4-beat write, then requester 1 wins first.
    req = 3'b001; req_wr = 3'b001; req_len = {4'd0, 4'd0, 4'd3}; req_wdata = {8'h00, 8'h00, 8'h5A};
    cyc();
    req = '0;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mrst_gnt",  32'(gnt),    32'(0));
    chk("mrst_busy", 32'(busy),   32'(0));
    chk("mrst_oe",   32'(uio_oe), 32'(8'h00));
    chk("mrst_done", 32'(done),   32'(0));
    req = 3'b110; req_wr = 3'b110; req_len = '0;
    cyc();
    req = '0;
    chk("mrst_regnt", 32'(gnt), 32'(3'b010));
    idle(4);

    // Requester drops req after the first beat of a 16-beat burst.
    beats_seen = 0; dones_seen = 0;
    req = 3'b001; req_wr = 3'b001; req_len = {4'd0, 4'd0, 4'd15}; req_wdata = {8'h00, 8'h00, 8'h77};
    cyc();
    req = '0;
    run(17);
    chk("drop_beats", 32'(beats_seen), 32'(16));
    chk("drop_dones", 32'(dones_seen), 32'(1));
    idle(2);

    // Owner changes direction and length mid-burst.
    beats_seen = 0; oe_beats = 0;
    req = 3'b001; req_wr = 3'b001; req_len = {4'd0, 4'd0, 4'd2};
    cyc();
    req_wr = 3'b000; req_len = {4'd0, 4'd0, 4'd15};
    cyc();
    req = '0;
    run(4);
    chk("chg_beats", 32'(beats_seen), 32'(3));
    chk("chg_oe",    32'(oe_beats),   32'(3));
    idle(2);

    // Random traffic including occasional resets.
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req       = NREQ'($urandom);
      req_wr    = NREQ'($urandom);
      req_len   = (NREQ*LENW)'($urandom);
      req_wdata = (NREQ*8)'($urandom);
      uio_in    = 8'($urandom);
      cyc();
    end
    rst = 1'b0;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uio_bus_arbiter.md
UIO_BUS_ARBITER -- requirements
Module: uio_bus_arbiter

Interface
REQ-001 Parameter: NREQ, 3, number of requesters sharing the uio bus.
REQ-002 Parameter: LENW, 4, burst length field width; a burst is len+1 beats (1..16).
REQ-003 Port: clk  in  1  sole clock; all state on rising edge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req  in  NREQ  per-requester bus request, level, held until granted.
REQ-006 Port: req_wr  in  NREQ  per-requester direction; 1=write (drive uio), 0=read (sample uio).
REQ-007 Port: req_len  in  NREQ*LENW  per-requester burst length minus one; requester i at bits [i*LENW +: LENW].
REQ-008 Port: req_wdata  in  NREQ*8  per-requester write byte; requester i at bits [i*8 +: 8]; sampled every write beat.
REQ-009 Port: gnt  out  NREQ  one-hot grant, high for every beat of the owner's burst.
REQ-010 Port: beat  out  1  high in each cycle a byte transfers.
REQ-011 Port: done  out  1  one-cycle pulse on the last beat of a burst.
REQ-012 Port: busy  out  1  high in every non-IDLE state.
REQ-013 Port: rdata  out  8  registered byte captured from uio_in on a read beat.
REQ-014 Port: rvalid  out  1  high for one cycle, the cycle after each read beat.
REQ-015 Port: uio_in  in  8  shared bidirectional bus, input path.
REQ-016 Port: uio_out  out  8  shared bus, output path.
REQ-017 Port: uio_oe  out  8  shared bus enables, all-ones or all-zeros only.

Function
REQ-018 FSM states: IDLE, XFER, TURN; encoding is free.
REQ-019 IDLE: when any req is high, select winner, latch owner index, direction and req_len into a beat counter, go to XFER next cycle; otherwise remain in IDLE.
REQ-020 Arbitration: round-robin; search starts at (last_owner+1) mod NREQ and takes the first requester with req high; last_owner updates on each grant.
REQ-021 Latency: req high in IDLE cycle N -> gnt and first beat in cycle N+1.
REQ-022 XFER: gnt=one-hot(owner), beat=1, busy=1; beat counter decrements each cycle; done=1 when counter==0, then go to TURN.
REQ-023 Write beat: uio_oe=8'hFF; uio_out=owner's req_wdata, combinational from the current cycle.
REQ-024 Read beat: uio_oe=8'h00; rdata<=uio_in at the clock edge ending the beat; rvalid=1 the following cycle.
REQ-025 Outside write beats: uio_out=8'h00, uio_oe=8'h00.
REQ-026 TURN: exactly one cycle; gnt=0, beat=0, uio_oe=8'h00, busy=1; then IDLE. This guarantees one bus-release cycle between owners.
REQ-027 The owner's direction and length are fixed at grant; changes to req, req_wr or req_len during XFER are ignored, and the burst always completes its full length.
REQ-028 Deasserting req while in XFER does not shorten the burst.
REQ-029 Minimum spacing between grants is 3 cycles for 1-beat bursts (XFER, TURN, IDLE).
REQ-030 A requester whose req stays high is re-granted only after every other active requester has been served once.

Reset
REQ-031 rst=1 at an edge: state=IDLE, last_owner=NREQ-1 (requester 0 wins first), counter=0, rdata=8'h00, rvalid=0.
REQ-032 Outputs during and after reset: gnt=0, beat=0, done=0, busy=0, uio_oe=8'h00, uio_out=8'h00.
REQ-033 Reset mid-burst: the burst is abandoned with no done pulse, and outputs match REQ-032 in the next cycle.

Verification
REQ-034 Single write: req=001, wr=1, len0=2, wdata0=A5 -> gnt=001 for 3 cycles, uio_oe=FF, uio_out=A5, done on 3rd beat, then one TURN cycle with uio_oe=00, then IDLE.
REQ-035 Round-robin: req=111 held, all len=0, all wr=1 -> grants go 001, 010, 100, 001, with one grant every 3 cycles.
REQ-036 Read burst: req=010, wr1=0, len1=1, uio_in=3C then C3 -> uio_oe=00; rdata=3C then C3, each with rvalid one cycle after its beat.
REQ-037 Reset mid-burst: rst pulsed during beat 2 of a 4-beat write -> next cycle gnt=0, uio_oe=00, busy=0, no done; then req=110 -> gnt=010 first.
REQ-038 Early drop: len0=15, req0 dropped after first beat -> all 16 beats occur and done is asserted on beat 16.
REQ-039 Mid-burst change: req_wr and req_len of the owner changed during XFER -> direction and beat count are unchanged.
